// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution front end.
// Holds the pixel format, the flush fill value and the frame sequencer state/error encodings.
package conv_pkg;

    localparam int PIXEL_W = 8;
    localparam logic [PIXEL_W-1:0] FILL_PIXEL = '0;

    localparam int ERR_EOL = 0;
    localparam int ERR_SOF = 1;
    localparam int ERR_CFG = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        FLUSH = 2'd2
    } conv_frame_seq_state_t;

endpackage

// File: rtl/conv_frame_seq_cnt.sv
// Column/row position counter for conv_frame_seq, shared by the pass-through and flush phases.
// Holds the frame geometry latched at start of frame and flags the last column / last pixel.
module conv_frame_seq_cnt
    import conv_pkg::*;
#(
    parameter int MAX_W = 1024,
    parameter int MAX_H = 1024,
    localparam int CW = $clog2(MAX_W),
    localparam int RW = $clog2(MAX_H),
    localparam int WW = $clog2(MAX_W + 1),
    localparam int HW = $clog2(MAX_H + 1)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          cfg_latch_i,
    input  logic [WW-1:0] cfg_width_i,
    input  logic [HW-1:0] cfg_height_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_col_i,
    input  logic [RW-1:0] load_row_i,
    input  logic          en_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic [WW-1:0] width_o,
    output logic          last_col_o,
    output logic          last_pix_o
);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [WW-1:0] width_q;
    logic [HW-1:0] height_q;
    logic          last_row;

    assign last_col_o = (WW'(col_q) == width_q - WW'(1));
    assign last_row   = (HW'(row_q) == height_q - HW'(1));
    assign last_pix_o = last_col_o && last_row;
    assign col_o      = col_q;
    assign row_o      = row_q;
    assign width_o    = width_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
        end else begin
            if (cfg_latch_i) begin
                width_q  <= cfg_width_i;
                height_q <= cfg_height_i;
            end
            if (load_i) begin
                col_q <= load_col_i;
                row_q <= load_row_i;
            end else if (en_i) begin
                if (last_col_o) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_frame_seq.sv
// Frame sequencer in front of conv_cntrl: validates the upstream AXI-S video geometry,
// regenerates SOF/EOL from counters and appends flush pixels so the 5x5 window drains.
module conv_frame_seq
    import conv_pkg::*;
#(
    parameter int MAX_W       = 1024,
    parameter int MAX_H       = 1024,
    parameter int FLUSH_LINES = 2,
    parameter int FLUSH_PIX   = 2
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic [$clog2(MAX_W+1)-1:0]   cfg_width_i,
    input  logic [$clog2(MAX_H+1)-1:0]   cfg_height_i,
    input  logic                         s_tvalid_i,
    input  logic [PIXEL_W-1:0]           s_tdata_i,
    input  logic                         s_tuser_i,
    input  logic                         s_tlast_i,
    output logic                         s_tready_o,
    output logic                         m_tvalid_o,
    output logic [PIXEL_W-1:0]           m_tdata_o,
    output logic                         m_tuser_o,
    output logic                         m_tlast_o,
    input  logic                         m_tready_i,
    output logic                         busy_o,
    output logic                         frame_done_o,
    output logic [2:0]                   err_o,
    input  logic                         err_clr_i
);

    localparam int CW = $clog2(MAX_W);
    localparam int RW = $clog2(MAX_H);
    localparam int WW = $clog2(MAX_W + 1);
    localparam int HW = $clog2(MAX_H + 1);
    localparam int FW = $clog2(FLUSH_LINES * MAX_W + FLUSH_PIX + 1);
    localparam logic [WW-1:0] W_MAX = WW'(MAX_W);
    localparam logic [HW-1:0] H_MAX = HW'(MAX_H);

    conv_frame_seq_state_t state_q, state_d;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [WW-1:0] width_lat;
    logic          last_col, last_pix;
    logic          cnt_en, cnt_load, cfg_latch;
    logic [FW-1:0] flush_q, flush_last_idx;
    logic          flush_clr, flush_inc, flush_last;
    logic          done_d, done_q;
    logic [2:0]    err_set, err_q;
    logic          cfg_ok, at_origin, resync;

    conv_frame_seq_cnt #(.MAX_W(MAX_W), .MAX_H(MAX_H)) u_cnt (
        .clk         (clk),
        .arst_n      (arst_n),
        .cfg_latch_i (cfg_latch),
        .cfg_width_i (cfg_width_i),
        .cfg_height_i(cfg_height_i),
        .load_i      (cnt_load),
        .load_col_i  (CW'(1)),
        .load_row_i  ('0),
        .en_i        (cnt_en),
        .col_o       (col),
        .row_o       (row),
        .width_o     (width_lat),
        .last_col_o  (last_col),
        .last_pix_o  (last_pix)
    );

    // Geometry below 3 cannot fill a 5x5 window with a radius-2 border.
    assign cfg_ok = (cfg_width_i >= WW'(3)) && (cfg_width_i <= W_MAX) &&
                    (cfg_height_i >= HW'(3)) && (cfg_height_i <= H_MAX);

    assign at_origin      = (col == '0) && (row == '0);
    assign resync         = s_tuser_i && !at_origin;
    assign flush_last_idx = FW'(FLUSH_LINES * int'(width_lat) + FLUSH_PIX - 1);
    assign flush_last     = (flush_q == flush_last_idx);

    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = done_q;
    assign err_o        = err_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d    = state_q;
        s_tready_o = 1'b1;
        m_tvalid_o = 1'b0;
        m_tdata_o  = s_tdata_i;
        m_tuser_o  = 1'b0;
        m_tlast_o  = 1'b0;
        cnt_en     = 1'b0;
        cnt_load   = 1'b0;
        cfg_latch  = 1'b0;
        flush_clr  = 1'b0;
        flush_inc  = 1'b0;
        done_d     = 1'b0;
        err_set    = '0;
        unique case (state_q)
            IDLE: begin
                if (s_tvalid_i && s_tuser_i) begin
                    if (cfg_ok) begin
                        m_tvalid_o = 1'b1;
                        m_tuser_o  = 1'b1;
                        s_tready_o = m_tready_i;
                        if (m_tready_i) begin
                            cfg_latch = 1'b1;
                            cnt_load  = 1'b1;
                            state_d   = PASS;
                        end
                    end else begin
                        err_set[ERR_CFG] = 1'b1;
                    end
                end
            end
            PASS: begin
                m_tvalid_o = s_tvalid_i;
                s_tready_o = m_tready_i;
                m_tuser_o  = at_origin || s_tuser_i;
                // A resynced beat becomes pixel (0,0), which is never the last column.
                m_tlast_o  = last_col && !resync;
                if (s_tvalid_i && m_tready_i) begin
                    err_set[ERR_EOL] = (s_tlast_i != m_tlast_o);
                    if (resync) begin
                        err_set[ERR_SOF] = 1'b1;
                        cnt_load         = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                        if (last_pix) begin
                            flush_clr = 1'b1;
                            state_d   = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                s_tready_o = 1'b0;
                m_tvalid_o = 1'b1;
                m_tdata_o  = FILL_PIXEL;
                m_tlast_o  = last_col;
                if (m_tready_i) begin
                    cnt_en = 1'b1;
                    if (flush_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        flush_inc = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            flush_q <= '0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (flush_clr) begin
                flush_q <= '0;
            end else if (flush_inc) begin
                flush_q <= flush_q + 1'b1;
            end
            if (err_clr_i) begin
                err_q <= '0;
            end else begin
                err_q <= err_q | err_set;
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_seq.sv
// Self-checking bench for conv_frame_seq: random pixel data and back-pressure,
// compared against a position-based reference model of the expected output stream.
module tb_conv_frame_seq;
    import conv_pkg::*;

    localparam int MAX_W = 1024;
    localparam int MAX_H = 1024;
    localparam int FL    = 2;
    localparam int FP    = 2;

    typedef struct packed {
        logic [PIXEL_W-1:0] d;
        logic               u;
        logic               l;
    } beat_t;

    logic                         clk;
    logic                         arst_n;
    logic [$clog2(MAX_W+1)-1:0]   cfg_width_i;
    logic [$clog2(MAX_H+1)-1:0]   cfg_height_i;
    logic                         s_tvalid_i;
    logic [PIXEL_W-1:0]           s_tdata_i;
    logic                         s_tuser_i;
    logic                         s_tlast_i;
    logic                         s_tready_o;
    logic                         m_tvalid_o;
    logic [PIXEL_W-1:0]           m_tdata_o;
    logic                         m_tuser_o;
    logic                         m_tlast_o;
    logic                         m_tready_i;
    logic                         busy_o;
    logic                         frame_done_o;
    logic [2:0]                   err_o;
    logic                         err_clr_i;

    conv_frame_seq #(.MAX_W(MAX_W), .MAX_H(MAX_H), .FLUSH_LINES(FL), .FLUSH_PIX(FP)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .cfg_width_i (cfg_width_i),
        .cfg_height_i(cfg_height_i),
        .s_tvalid_i  (s_tvalid_i),
        .s_tdata_i   (s_tdata_i),
        .s_tuser_i   (s_tuser_i),
        .s_tlast_i   (s_tlast_i),
        .s_tready_o  (s_tready_o),
        .m_tvalid_o  (m_tvalid_o),
        .m_tdata_o   (m_tdata_o),
        .m_tuser_o   (m_tuser_o),
        .m_tlast_o   (m_tlast_o),
        .m_tready_i  (m_tready_i),
        .busy_o      (busy_o),
        .frame_done_o(frame_done_o),
        .err_o       (err_o),
        .err_clr_i   (err_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    beat_t in_q[$];
    beat_t exp_q[$];
    beat_t got_q[$];
    int    tready_bad, hold_bad, done_cnt, done_gap;
    bit    timed_out;

    // Upstream stream of n beats; position restarts at beat index r (r < 0: no restart).
    function automatic void make_stream(input int w, input int n, input int r);
        beat_t b;
        in_q.delete();
        for (int i = 0; i < n; i++) begin
            int p;
            p   = (r >= 0 && i >= r) ? i - r : i;
            b.d = 8'($urandom_range(1, 255));
            b.u = (p == 0);
            b.l = ((p % w) == w - 1);
            in_q.push_back(b);
        end
    endfunction

    // Expected downstream stream: each pixel tagged by its frame position, then the fill tail.
    function automatic void model(input int w, input int r);
        beat_t b;
        exp_q.delete();
        for (int i = 0; i < in_q.size(); i++) begin
            int p;
            p   = (r >= 0 && i >= r) ? i - r : i;
            b.d = in_q[i].d;
            b.u = (p == 0);
            b.l = ((p % w) == w - 1);
            exp_q.push_back(b);
        end
        for (int k = 0; k < FL * w + FP; k++) begin
            b.d = FILL_PIXEL;
            b.u = 1'b0;
            b.l = ((k % w) == w - 1);
            exp_q.push_back(b);
        end
    endfunction

    task automatic stream(input int ready_mode, input bit gap, input int abort_at);
        int    idx;
        int    last_out;
        logic  prev_stall;
        logic [PIXEL_W-1:0] prev_d;
        beat_t b;
        idx = 0; last_out = -1; prev_stall = 1'b0; prev_d = '0;
        got_q.delete();
        tready_bad = 0; hold_bad = 0; done_cnt = 0; done_gap = -1; timed_out = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (idx < in_q.size()) begin
                s_tvalid_i = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_tdata_i  = in_q[idx].d;
                s_tuser_i  = in_q[idx].u;
                s_tlast_i  = in_q[idx].l;
            end else begin
                s_tvalid_i = 1'b0;
                s_tuser_i  = 1'b0;
                s_tlast_i  = 1'b0;
            end
            case (ready_mode)
                0:       m_tready_i = 1'b1;
                1:       m_tready_i = ((cyc % 2) == 1);
                default: m_tready_i = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (abort_at >= 0 && got_q.size() == abort_at && m_tvalid_o === 1'b1) begin
                timed_out = 1'b0;
                return;
            end
            if (idx > 0 && idx < in_q.size() && s_tready_o !== m_tready_i) tready_bad++;
            if (prev_stall && (m_tvalid_o !== 1'b1 || m_tdata_o !== prev_d)) hold_bad++;
            prev_stall = (idx == in_q.size()) && m_tvalid_o && !m_tready_i;
            prev_d     = m_tdata_o;
            if (frame_done_o === 1'b1) begin
                done_cnt++;
                done_gap = cyc - last_out;
            end
            if (m_tvalid_o === 1'b1 && m_tready_i) begin
                b.d = m_tdata_o; b.u = m_tuser_o; b.l = m_tlast_o;
                got_q.push_back(b);
                last_out = cyc;
            end
            if (s_tvalid_i && s_tready_o === 1'b1) idx++;
            if (got_q.size() >= exp_q.size() && last_out >= 0 && cyc - last_out >= 3) begin
                timed_out = 1'b0;
                break;
            end
        end
        s_tvalid_i = 1'b0;
        s_tuser_i  = 1'b0;
        s_tlast_i  = 1'b0;
        m_tready_i = 1'b1;
    endtask

    task automatic test_reset;
        arst_n = 1'b1;
        #2 arst_n = 1'b0;
        #3;
        total += 5;
        if (m_tvalid_o !== 1'b0)   begin bad++; $display("FAIL rst_mvalid got=%b want=0", m_tvalid_o); end
        if (s_tready_o !== 1'b1)   begin bad++; $display("FAIL rst_sready got=%b want=1", s_tready_o); end
        if (busy_o !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b want=0", busy_o); end
        if (frame_done_o !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", frame_done_o); end
        if (err_o !== 3'b000)      begin bad++; $display("FAIL rst_err got=%b want=000", err_o); end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_geometry;
        cfg_width_i = 4; cfg_height_i = 3;
        make_stream(4, 12, -1);
        model(4, -1);
        stream(0, 1'b0, -1);
        total++;
        if (got_q.size() !== exp_q.size() || timed_out) begin
            bad++; $display("FAIL geom_len got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL geom_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        total += 3;
        if (done_cnt !== 1) begin bad++; $display("FAIL geom_done_cnt got=%0d want=1", done_cnt); end
        if (done_gap !== 1) begin bad++; $display("FAIL geom_done_gap got=%0d want=1", done_gap); end
        if (err_o !== 3'b000) begin bad++; $display("FAIL geom_err got=%b want=000", err_o); end
    endtask

    task automatic test_backpressure;
        cfg_width_i = 4; cfg_height_i = 3;
        stream(1, 1'b0, -1);
        total++;
        if (got_q.size() !== exp_q.size() || timed_out) begin
            bad++; $display("FAIL bp_len got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL bp_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        total += 4;
        if (tready_bad !== 0) begin bad++; $display("FAIL bp_sready got=%0d want=0", tready_bad); end
        if (hold_bad !== 0)   begin bad++; $display("FAIL bp_hold got=%0d want=0", hold_bad); end
        if (done_cnt !== 1)   begin bad++; $display("FAIL bp_done_cnt got=%0d want=1", done_cnt); end
        if (done_gap !== 1)   begin bad++; $display("FAIL bp_done_gap got=%0d want=1", done_gap); end
    endtask

    task automatic test_bad_tlast;
        cfg_width_i = 4; cfg_height_i = 3;
        make_stream(4, 12, -1);
        in_q[2].l = 1'b1;
        in_q[3].l = 1'b0;
        model(4, -1);
        stream(0, 1'b0, -1);
        total++;
        if (got_q.size() !== exp_q.size() || timed_out) begin
            bad++; $display("FAIL eol_len got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL eol_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        total++;
        if (err_o !== 3'b001) begin bad++; $display("FAIL eol_err got=%b want=001", err_o); end
        @(negedge clk); err_clr_i = 1'b1;
        @(negedge clk); err_clr_i = 1'b0;
        #1;
        total++;
        if (err_o !== 3'b000) begin bad++; $display("FAIL eol_clr got=%b want=000", err_o); end
    endtask

    task automatic test_resync;
        cfg_width_i = 4; cfg_height_i = 3;
        make_stream(4, 17, 5);
        model(4, 5);
        stream(2, 1'b0, -1);
        total++;
        if (got_q.size() !== exp_q.size() || timed_out) begin
            bad++; $display("FAIL sof_len got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL sof_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        total += 2;
        if (err_o !== 3'b010) begin bad++; $display("FAIL sof_err got=%b want=010", err_o); end
        if (done_cnt !== 1)   begin bad++; $display("FAIL sof_done got=%0d want=1", done_cnt); end
        @(negedge clk); err_clr_i = 1'b1;
        @(negedge clk); err_clr_i = 1'b0;
    endtask

    task automatic test_bad_config;
        m_tready_i = 1'b1;
        cfg_width_i = 2; cfg_height_i = 3;
        @(negedge clk);
        s_tvalid_i = 1'b1; s_tuser_i = 1'b1; s_tdata_i = 8'h5a; s_tlast_i = 1'b0;
        #1;
        total += 2;
        if (s_tready_o !== 1'b1) begin bad++; $display("FAIL cfg_sready got=%b want=1", s_tready_o); end
        if (m_tvalid_o !== 1'b0) begin bad++; $display("FAIL cfg_mvalid got=%b want=0", m_tvalid_o); end
        @(negedge clk);
        s_tvalid_i = 1'b0; s_tuser_i = 1'b0;
        #1;
        total += 2;
        if (err_o !== 3'b100) begin bad++; $display("FAIL cfg_err got=%b want=100", err_o); end
        if (busy_o !== 1'b0)  begin bad++; $display("FAIL cfg_busy got=%b want=0", busy_o); end
        cfg_width_i = 4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_tvalid_i = 1'b1; s_tuser_i = 1'b0; s_tdata_i = 8'($urandom_range(1, 255));
            #1;
            total += 2;
            if (m_tvalid_o !== 1'b0) begin bad++; $display("FAIL drop_mvalid%0d got=%b want=0", i, m_tvalid_o); end
            if (s_tready_o !== 1'b1) begin bad++; $display("FAIL drop_sready%0d got=%b want=1", i, s_tready_o); end
        end
        // Clear and a new oversize-config error in the same cycle: the clear wins.
        @(negedge clk);
        cfg_width_i = 11'd1025; s_tuser_i = 1'b1; err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        #1;
        total++;
        if (err_o !== 3'b000) begin bad++; $display("FAIL cfg_clr_prio got=%b want=000", err_o); end
        @(negedge clk);
        s_tvalid_i = 1'b0; s_tuser_i = 1'b0;
        #1;
        total += 2;
        if (err_o !== 3'b100) begin bad++; $display("FAIL cfg_wide got=%b want=100", err_o); end
        if (busy_o !== 1'b0)  begin bad++; $display("FAIL cfg_wide_busy got=%b want=0", busy_o); end
        @(negedge clk); err_clr_i = 1'b1;
        @(negedge clk); err_clr_i = 1'b0;
    endtask

    task automatic test_reset_mid_flush;
        cfg_width_i = 4; cfg_height_i = 3;
        make_stream(4, 12, -1);
        in_q[1].l = 1'b1;
        model(4, -1);
        stream(0, 1'b0, 16);
        total++;
        if (timed_out) begin bad++; $display("FAIL mid_reach got=timeout want=flush_beat5"); end
        arst_n = 1'b0;
        #1;
        total += 3;
        if (m_tvalid_o !== 1'b0) begin bad++; $display("FAIL mid_mvalid got=%b want=0", m_tvalid_o); end
        if (busy_o !== 1'b0)     begin bad++; $display("FAIL mid_busy got=%b want=0", busy_o); end
        if (err_o !== 3'b000)    begin bad++; $display("FAIL mid_err got=%b want=000", err_o); end
        @(negedge clk);
        arst_n = 1'b1;
        make_stream(4, 12, -1);
        model(4, -1);
        stream(0, 1'b0, -1);
        total++;
        if (got_q.size() !== exp_q.size() || timed_out) begin
            bad++; $display("FAIL mid_len got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL mid_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        total += 2;
        if (done_cnt !== 1)   begin bad++; $display("FAIL mid_done got=%0d want=1", done_cnt); end
        if (err_o !== 3'b000) begin bad++; $display("FAIL mid_err2 got=%b want=000", err_o); end
    endtask

    task automatic test_random;
        for (int t = 0; t < 4; t++) begin
            int w, h;
            w = $urandom_range(3, 8);
            h = $urandom_range(3, 5);
            cfg_width_i  = 11'(w);
            cfg_height_i = 11'(h);
            make_stream(w, w * h, -1);
            model(w, -1);
            stream(2, 1'b1, -1);
            total++;
            if (got_q.size() !== exp_q.size() || timed_out) begin
                bad++; $display("FAIL rnd%0d_len got=%0d want=%0d", t, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL rnd%0d_beat%0d got=%h want=%h", t, i, got_q[i], exp_q[i]);
                end
            end
            total += 5;
            if (tready_bad !== 0) begin bad++; $display("FAIL rnd%0d_sready got=%0d want=0", t, tready_bad); end
            if (hold_bad !== 0)   begin bad++; $display("FAIL rnd%0d_hold got=%0d want=0", t, hold_bad); end
            if (done_cnt !== 1)   begin bad++; $display("FAIL rnd%0d_done got=%0d want=1", t, done_cnt); end
            if (done_gap !== 1)   begin bad++; $display("FAIL rnd%0d_gap got=%0d want=1", t, done_gap); end
            if (err_o !== 3'b000) begin bad++; $display("FAIL rnd%0d_err got=%b want=000", t, err_o); end
        end
    endtask

    initial begin
        arst_n       = 1'b1;
        cfg_width_i  = '0;
        cfg_height_i = '0;
        s_tvalid_i   = 1'b0;
        s_tdata_i    = '0;
        s_tuser_i    = 1'b0;
        s_tlast_i    = 1'b0;
        m_tready_i   = 1'b1;
        err_clr_i    = 1'b0;
        test_reset;
        test_geometry;
        test_backpressure;
        test_bad_tlast;
        test_resync;
        test_bad_config;
        test_reset_mid_flush;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_frame_seq.md
Name: conv_frame_seq

Overview:
- Frame sequencer in front of conv_cntrl.
- conv_cntrl needs an unbroken pixel stream, with SOF/EOL that exactly match the frame geometry. It has no way to drain its pipeline at end of frame.
- This block checks the upstream AXI-S video stream against the configured width and height, and regenerates tuser/tlast from internal counters.
- After the last pixel of each frame it injects flush pixels so the 5x5 window completes the bottom rows.

Parameters:
- MAX_W, 1024, maximum frame width in pixels.
- MAX_H, 1024, maximum frame height in lines.
- FLUSH_LINES, 2, number of whole flush lines injected after the frame (kernel radius).
- FLUSH_PIX, 2, number of extra flush pixels after the flush lines (column pipeline depth).

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- cfg_width_i  in  $clog2(MAX_W+1)  frame width; latched at SOF.
- cfg_height_i  in  $clog2(MAX_H+1)  frame height; latched at SOF.
- s_tvalid_i  in  1  upstream valid.
- s_tdata_i  in  conv_pkg::PIXEL_W  upstream pixel.
- s_tuser_i  in  1  upstream SOF.
- s_tlast_i  in  1  upstream EOL.
- s_tready_o  out  1  upstream ready.
- m_tvalid_o  out  1  valid to conv_cntrl.
- m_tdata_o  out  conv_pkg::PIXEL_W  pixel to conv_cntrl.
- m_tuser_o  out  1  regenerated SOF.
- m_tlast_o  out  1  regenerated EOL.
- m_tready_i  in  1  ready from conv_cntrl.
- busy_o  out  1  state is not IDLE.
- frame_done_o  out  1  single-cycle pulse when the flush completes.
- err_o  out  3  sticky errors: [0] early or late tlast, [1] unexpected tuser, [2] bad config.
- err_clr_i  in  1  clears err_o.

Behaviour:
- Reset (async, any time, including mid-frame or mid-flush):
  - state goes to IDLE; col, row and flush counters go to 0; err_o = 0.
  - m_tvalid_o = 0, frame_done_o = 0, busy_o = 0, s_tready_o = 1.
- Zero-latency datapath: m_tdata_o = s_tdata_i in PASS and conv_pkg::FILL_PIXEL in FLUSH. A beat transfers when valid & ready on the same edge.
- IDLE:
  - s_tready_o = 1 and m_tvalid_o = 0. Beats without tuser are dropped silently.
  - A tuser beat with W>=3 and H>=3 latches W/H, is forwarded to m_*, and moves the block to PASS.
  - The forwarded beat is accepted only when m_tready_i = 1. s_tready_o mirrors m_tready_i for that beat.
  - A tuser beat with W<3 or H<3 sets err[2]; the beat is dropped and the block stays in IDLE.
- PASS:
  - m_tvalid_o = s_tvalid_i and s_tready_o = m_tready_i.
  - m_tuser_o = (col==0 & row==0).
  - m_tlast_o = (col==W-1), taken from the counters and not from s_tlast_i.
  - col wraps from W-1 to 0 and increments row.
  - s_tlast_i differing from (col==W-1) on an accepted beat sets err[0]. The counters are not affected.
  - s_tuser_i on an accepted beat that is not at (0,0) sets err[1] and resyncs: that beat is emitted as SOF and the counters restart from col=1, row=0.
  - Acceptance at (W-1, H-1) moves the block to FLUSH and sets flush_cnt = 0.
- FLUSH:
  - s_tready_o = 0 and m_tvalid_o = 1.
  - m_tuser_o = 0; m_tlast_o follows the continuing col counter.
  - Total flush beats = FLUSH_LINES*W + FLUSH_PIX.
  - After the final beat is accepted, the block moves to IDLE and frame_done_o pulses for one cycle on the next cycle.
- err_clr_i has priority over setting an error bit in the same cycle. Error bits never affect data flow except err[2].
- m_tready_i low freezes all counters and state; m_tvalid_o and m_tdata_o must hold stable while stalled in FLUSH.
- Width rules:
  - col is $clog2(MAX_W); row is $clog2(MAX_H).
  - The flush counter is wide enough for FLUSH_LINES*MAX_W + FLUSH_PIX.
  - W and H above MAX_W/MAX_H are bad config: set err[2].

Decomposition:
- conv_pkg additions:
  - FILL_PIXEL constant.
  - conv_frame_seq_state_t enum {IDLE, PASS, FLUSH}.
  - ERR_EOL, ERR_SOF and ERR_CFG bit-index localparams.
- One sub-module, conv_frame_seq_cnt: col/row counter with enable, sync restart-to-(col,row) load, latched W/H, and outputs last_col and last_pix. It is shared by the PASS and FLUSH states.

Test Plan:
- Frame geometry: W=4, H=3, 12 beats with correct tuser/tlast and m_tready=1.
  - m_tuser only on beat 1; m_tlast on beats 4, 8, 12.
  - Then 10 FILL beats with m_tlast on flush beats 4 and 8.
  - frame_done pulses once, one cycle after flush beat 10; err_o = 0.
- Back-pressure: same frame with m_tready toggled every other cycle.
  - Output sequence is identical to the first test.
  - s_tready_o equals m_tready_i throughout PASS; FILL data holds while stalled.
- Mismatched tlast: W=4, upstream tlast on beat 3 and missing on beat 4.
  - err_o = 3'b001; m_tlast still on beats 4, 8, 12.
  - err_clr_i for one cycle gives err_o = 0.
- Unexpected tuser: tuser on beat 6 of a W=4, H=3 frame.
  - err_o[1] = 1; beat 6 is emitted with m_tuser = 1.
  - FLUSH is entered after 12 further beats counted from beat 6.
- Bad config and dropped beats:
  - W=2 with a tuser beat gives err_o[2] = 1, the beat is dropped, and busy_o = 0.
  - Non-tuser beats in IDLE give m_tvalid_o = 0 and s_tready_o = 1.
- Reset mid-flush: deassert arst_n during flush beat 5.
  - Immediately m_tvalid_o = 0, busy_o = 0, err_o = 0.
  - After release, a new W=4, H=3 frame passes exactly as in the first test.
